// File: rtl/tutorial_aula_mem_tester.sv
// tutorial_aula_mem_tester
// Avalon-MM self-test master. It fills a word region with a pattern, reads the
// region back with up to MAX_PENDING reads in flight, and reports the mismatch
// count and the first failing word address.
// Build option: define TUTORIAL_AULA_MEM_TESTER_ADDR_XOR_EN to fold each word's
// address into its expected data, which exposes stuck or aliased address lines.
module tutorial_aula_mem_tester #(
    parameter int ADDR_W      = 13,
    parameter int MAX_PENDING = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       pattern,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);
    localparam logic [2:0]      PEND_MAX = 3'(MAX_PENDING);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       pattern_q;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   ret;
    logic [2:0]        pending;
    logic [ADDR_W-1:0] idx_waddr;
    logic [ADDR_W-1:0] ret_waddr;
    logic [31:0]       idx_expected;
    logic [31:0]       ret_expected;
    logic              idx_last;
    logic              wr_acc;
    logic              rd_acc;
    logic              rsp_take;
    logic              rsp_bad;

    // Word addresses wrap naturally by truncation to ADDR_W bits.
    assign idx_waddr = base_q + idx[ADDR_W-1:0];
    assign ret_waddr = base_q + ret[ADDR_W-1:0];
    assign idx_last  = (idx + IDX_ONE) == count_q;

`ifdef TUTORIAL_AULA_MEM_TESTER_ADDR_XOR_EN
    assign idx_expected = pattern_q ^ {{(32-ADDR_W){1'b0}}, idx_waddr};
    assign ret_expected = pattern_q ^ {{(32-ADDR_W){1'b0}}, ret_waddr};
`else
    assign idx_expected = pattern_q;
    assign ret_expected = pattern_q;
`endif

    assign wr_acc   = avm_write & ~avm_waitrequest;
    assign rd_acc   = avm_read & ~avm_waitrequest;
    // Responses are only meaningful while a read phase is live; anything else
    // (e.g. stragglers after a reset) is dropped.
    assign rsp_take = avm_readdatavalid && (state == S_READ || state == S_DRAIN)
                      && (ret != count_q);
    assign rsp_bad  = rsp_take && (avm_readdata != ret_expected);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            // A zero-length run passes through DRAIN so done lands two cycles
            // after start, like every other completion path.
            S_IDLE:  if (start) state_next = (word_count == '0) ? S_DRAIN : S_WRITE;
            S_WRITE: if (wr_acc && idx_last) state_next = S_READ;
            S_READ:  if (rd_acc && idx_last) state_next = S_DRAIN;
            S_DRAIN: if (pending == '0 && ret == count_q) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus commands and status outputs decoded from the current state.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_byteenable = 4'hF;
        case (state)
            S_WRITE: begin
                busy          = 1'b1;
                avm_write     = 1'b1;
                avm_address   = {idx_waddr, 2'b00};
                avm_writedata = idx_expected;
            end
            S_READ: begin
                busy = 1'b1;
                // pending can only fall while a read is stalled, so an issued
                // read stays asserted until accepted.
                if (pending < PEND_MAX) begin
                    avm_read    = 1'b1;
                    avm_address = {idx_waddr, 2'b00};
                end
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Run parameters, issue/return indices, outstanding reads and results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q         <= '0;
            count_q        <= '0;
            pattern_q      <= '0;
            idx            <= '0;
            ret            <= '0;
            pending        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                base_q         <= base_addr;
                count_q        <= word_count;
                pattern_q      <= pattern;
                idx            <= '0;
                ret            <= '0;
                pending        <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end
            if (wr_acc) begin
                idx <= idx_last ? '0 : idx + IDX_ONE;
            end
            if (rd_acc) begin
                idx <= idx + IDX_ONE;
            end
            case ({rd_acc, rsp_take})
                2'b10:   pending <= pending + 3'd1;
                2'b01:   pending <= pending - 3'd1;
                default: ;
            endcase
            if (rsp_take) begin
                ret <= ret + IDX_ONE;
                if (rsp_bad) begin
                    if (err_count != '1) begin
                        err_count <= err_count + 16'd1;
                    end
                    if (err_count == '0) begin
                        first_err_addr <= ret_waddr;
                    end
                end
            end
            // No response can arrive on the DRAIN->DONE edge, so err_count is final.
            if (state == S_DRAIN && state_next == S_DONE) begin
                pass <= (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_tutorial_aula_mem_tester.sv
// Testbench for tutorial_aula_mem_tester: memory-model slave with configurable
// latency, random waitrequest and readback corruption; expected bus traffic and
// run results are queued at stimulus time and checked by a separate monitor.
module tb_tutorial_aula_mem_tester;

    localparam int ADDR_W      = 13;
    localparam int MAX_PENDING = 2;
`ifdef TUTORIAL_AULA_MEM_TESTER_ADDR_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       pattern;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest   = 1'b0;
    logic [31:0]       avm_readdata      = '0;
    logic              avm_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    tutorial_aula_mem_tester #(
        .ADDR_W     (ADDR_W),
        .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .base_addr        (base_addr),
        .word_count       (word_count),
        .pattern          (pattern),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_err_addr   (first_err_addr),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_byteenable   (avm_byteenable),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    typedef struct {
        logic [14:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        int err;
        int first;
        bit pass;
        int done_at;
        int start_at;
    } run_t;
    typedef struct {
        logic [12:0] waddr;
        int          due;
    } rsp_t;

    wr_t         exp_wq[$];
    logic [14:0] exp_rq[$];
    run_t        exp_runq[$];
    rsp_t        rsp_q[$];
    logic [31:0] mem[0:8191];

    int   cyc          = 0;
    int   total        = 0;
    int   bad          = 0;
    int   outstanding  = 0;
    int   late_rdv     = 0;
    int   lat          = 1;
    int   wait_pct     = 0;
    int   corrupt_addr = -1;
    bit   corrupt_all  = 1'b0;
    bit   late_phase   = 1'b0;

    rsp_t        cur_rsp;
    run_t        mon_run;
    wr_t         mon_wr;
    logic [14:0] mon_ra;
    logic        prev_w = 1'b0;
    logic        prev_r = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [12:0] a, input logic [31:0] p);
        return p ^ (XOR_EN ? {19'd0, a} : 32'd0);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-model slave: drives waitrequest/readdata at the falling edge.
    always @(negedge clk) begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            cur_rsp           = rsp_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem[cur_rsp.waddr];
            if (corrupt_all || int'(cur_rsp.waddr) == corrupt_addr)
                avm_readdata = avm_readdata ^ 32'h0000_0100;
            if (late_phase) late_rdv++;
        end
        avm_waitrequest = (wait_pct > 0) && (int'($urandom_range(99)) < wait_pct);
        if (avm_write && !avm_waitrequest) mem[avm_address[14:2]] = avm_writedata;
        if (avm_read && !avm_waitrequest)
            rsp_q.push_back('{waddr: avm_address[14:2], due: cyc + lat});
    end

    // Monitor: compares bus traffic and run results against the queues.
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            prev_w      = 1'b0;
            prev_r      = 1'b0;
            outstanding = 0;
        end else begin
            if (prev_w) begin
                check("wr_hold_cmd", 32'(avm_write), 32'd1);
                check("wr_hold_addr", 32'(avm_address), 32'(prev_addr));
                check("wr_hold_data", avm_writedata, prev_data);
            end
            if (prev_r) begin
                check("rd_hold_cmd", 32'(avm_read), 32'd1);
                check("rd_hold_addr", 32'(avm_address), 32'(prev_addr));
            end
            if (avm_readdatavalid && outstanding > 0) outstanding--;
            if (avm_write && !avm_waitrequest) begin
                if (exp_wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr %0h, none expected", avm_address);
                end else begin
                    mon_wr = exp_wq.pop_front();
                    check("wr_addr", 32'(avm_address), 32'(mon_wr.addr));
                    check("wr_data", avm_writedata, mon_wr.data);
                end
            end
            if (avm_read && !avm_waitrequest) begin
                outstanding++;
                check("pending_limit", 32'(outstanding <= MAX_PENDING), 32'd1);
                if (exp_rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read: addr %0h, none expected", avm_address);
                end else begin
                    mon_ra = exp_rq.pop_front();
                    check("rd_addr", 32'(avm_address), 32'(mon_ra));
                end
            end
            if (done) begin
                if (exp_runq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
                end else begin
                    mon_run = exp_runq.pop_front();
                    check("err_count", 32'(err_count), mon_run.err);
                    check("first_err_addr", 32'(first_err_addr), mon_run.first);
                    check("pass", 32'(pass), 32'(mon_run.pass));
                    check("busy_at_done", 32'(busy), 32'd0);
                    if (mon_run.done_at >= 0)
                        check("done_cycle", cyc - mon_run.start_at, mon_run.done_at);
                end
            end
            prev_w    = avm_write && avm_waitrequest;
            prev_r    = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            prev_data = avm_writedata;
        end
    end

    task automatic start_run(input logic [12:0] base, input logic [13:0] count,
                             input logic [31:0] pat, input int e_err, input int e_first,
                             input bit e_pass, input int e_done, input bit expect_done);
        logic [12:0] a;
        run_t        r;
        for (int i = 0; i < int'(count); i++) begin
            a = base + 13'(i);
            exp_wq.push_back('{addr: {a, 2'b00}, data: exp_data(a, pat)});
            exp_rq.push_back({a, 2'b00});
        end
        if (expect_done) begin
            r = '{err: e_err, first: e_first, pass: e_pass, done_at: e_done, start_at: cyc};
            exp_runq.push_back(r);
        end
        base_addr  = base;
        word_count = count;
        pattern    = pat;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input int budget);
        int n = 0;
        while (exp_runq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_runq.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected done", name, budget);
            exp_runq.delete();
        end
        repeat (8) @(negedge clk);
        check({name, "_writes_left"}, exp_wq.size(), 32'd0);
        check({name, "_reads_left"}, exp_rq.size(), 32'd0);
        exp_wq.delete();
        exp_rq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        pattern    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_first", 32'(first_err_addr), 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 16 words, zero-wait, latency 1: done at cycle 35.
        lat = 1; wait_pct = 0;
        start_run(13'h0000, 14'd16, 32'hA5A5_5A5A, 0, 0, 1'b1, 35, 1'b1);
        check("a_busy_c1", 32'(busy), 32'd1);
        check("a_write_c1", 32'(avm_write), 32'd1);
        check("a_byteen", 32'(avm_byteenable), 32'hF);
        finish_run("a", 200);

        // Word 0x105 corrupted on readback.
        corrupt_addr = 'h105;
        start_run(13'h0100, 14'd8, 32'h1234_5678, 1, 'h105, 1'b0, 19, 1'b1);
        finish_run("b", 200);
        corrupt_addr = -1;

        // Zero-length run: no traffic, done at cycle 2, previous errors cleared.
        start_run(13'h0055, 14'd0, 32'hFFFF_FFFF, 0, 0, 1'b1, 2, 1'b1);
        finish_run("e", 50);

        // Random stalls, latency 3.
        lat = 3; wait_pct = 50;
        start_run(13'h0040, 14'd16, 32'hDEAD_BEEF, 0, 0, 1'b1, -1, 1'b1);
        finish_run("c", 1000);

        // Address wrap at the top of the region.
        lat = 1; wait_pct = 0;
        start_run(13'h1FFE, 14'd4, 32'h0F0F_F0F0, 0, 0, 1'b1, 11, 1'b1);
        check("d_byte0", 32'(avm_address), 32'h7FF8);
        @(negedge clk);
        check("d_byte1", 32'(avm_address), 32'h7FFC);
        @(negedge clk);
        check("d_byte2", 32'(avm_address), 32'h0000);
        @(negedge clk);
        check("d_byte3", 32'(avm_address), 32'h0004);
        finish_run("d", 200);

        // start pulsed mid-run must be ignored.
        lat = 1; wait_pct = 25;
        start_run(13'h0200, 14'd32, 32'h55AA_33CC, 0, 0, 1'b1, -1, 1'b1);
        repeat (10) @(negedge clk);
        base_addr  = 13'h0999;
        word_count = 14'd5;
        pattern    = 32'h0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run("f", 1000);

        // Reset while reads are outstanding.
        lat = 3; wait_pct = 0;
        start_run(13'h0300, 14'd16, 32'hCAFE_F00D, 0, 0, 1'b0, -1, 1'b0);
        for (int n = 0; n < 100 && !(avm_read && outstanding >= 1); n++) @(negedge clk);
        check("g_reads_pending", 32'(avm_read && outstanding >= 1), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("g_rst_read", 32'(avm_read), 32'd0);
        check("g_rst_write", 32'(avm_write), 32'd0);
        check("g_rst_addr", 32'(avm_address), 32'd0);
        check("g_rst_wdata", avm_writedata, 32'd0);
        check("g_rst_busy", 32'(busy), 32'd0);
        check("g_rst_err", 32'(err_count), 32'd0);
        late_phase  = 1'b1;
        corrupt_all = 1'b1;
        reset_n     = 1'b1;
        exp_wq.delete();
        exp_rq.delete();
        repeat (8) @(negedge clk);
        check("g_late_rdv_seen", 32'(late_rdv != 0), 32'd1);
        check("g_late_err", 32'(err_count), 32'd0);
        check("g_late_busy", 32'(busy), 32'd0);
        check("g_late_read", 32'(avm_read), 32'd0);
        late_phase  = 1'b0;
        corrupt_all = 1'b0;

        // Recovery run after the reset.
        lat = 1;
        start_run(13'h0000, 14'd2, 32'h0000_0001, 0, 0, 1'b1, 7, 1'b1);
        finish_run("h", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
